dma_io_port: RTL and testbench
==============================

Name: dma_io_port

Overview:
- Peripheral-side DMA port that sits directly upstream/downstream of the DMAC on its I/O side.
- Generates DREQ toward the DMAC and answers the DMAC's DACK/IOR/IOW/EOP strobes.
- Buffers bytes in two FIFOs:
  - RX: device -> DMAC Data_in, for IO-to-memory transfers.
  - TX: DMAC Data_out -> device, for memory-to-IO transfers.
- Lets the DMAC run single or burst transfers against a real streaming device.

Parameters:
- DW, 8, data width; matches the DMAC byte bus.
- DEPTH, 8, entries per FIFO; power of 2, minimum 2.
- THRESH, 1, DREQ threshold: RX occupancy (DIR=0) or TX free slots (DIR=1) needed to raise DREQ; range 1..DEPTH.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  arm request generation; low forces return to IDLE.
- DIR  in  1  0 = IO-to-mem (RX), 1 = mem-to-IO (TX); sampled only in IDLE.
- DREQ  out  1  DMA request to DMAC.
- DACK  in  1  DMA acknowledge from DMAC.
- IOR  in  1  DMAC I/O read strobe (pop RX).
- IOW  in  1  DMAC I/O write strobe (push TX).
- EOP  in  1  end of process from DMAC.
- RDY  out  1  port ready; strobes are ignored while low.
- DOUT  out  DW  byte to DMAC Data_in.
- DIN  in  DW  byte from DMAC Data_out.
- DEV_WVALID  in  1  device offers byte to RX.
- DEV_WDATA  in  DW  device byte.
- DEV_WREADY  out  1  RX not full.
- DEV_RVALID  out  1  TX not empty.
- DEV_RDATA  out  DW  TX head byte.
- DEV_RREADY  in  1  device consumes TX byte.
- DONE  out  1  one-cycle pulse when EOP ends a transfer.

Behaviour:
- Reset: synchronous on RST=1 at a clock edge; overrides everything, including mid-transfer.
  - Both FIFOs emptied; state IDLE; dir_q=0.
  - DREQ=0, RDY=0, DONE=0, DOUT=0, DEV_WREADY=1, DEV_RVALID=0.
- FIFOs:
  - Standard synchronous, first-word-fall-through, count 0..DEPTH.
  - Push ignored when full; pop ignored when empty.
  - Simultaneous push and pop on a non-empty FIFO both occur; count unchanged.
  - Pointers wrap modulo DEPTH.
- Device side:
  - RX push when DEV_WVALID & DEV_WREADY.
  - TX pop when DEV_RVALID & DEV_RREADY.
  - Both are active in every state.
- Condition C: dir_q=0 -> rx_count >= THRESH; dir_q=1 -> (DEPTH - tx_count) >= THRESH.
- RDY (combinational): in XFER only; dir_q=0 -> RX not empty; dir_q=1 -> TX not full; 0 in all other states.
- DOUT (combinational): RX head when DACK=1 and dir_q=0, else 0.
- DMA-side FIFO access:
  - RX pop on an edge with XFER & DACK & IOR & RDY & dir_q=0.
  - TX push of DIN on an edge with XFER & DACK & IOW & RDY & dir_q=1.
  - Strobes in the wrong direction are ignored.
- FSM (registered state; DREQ is a registered output):
  - IDLE: DREQ=0; dir_q<=DIR. If EN & C -> REQ, with DREQ=1 from the next cycle.
  - REQ: DREQ=1, held until DACK.
    - EN=0 -> IDLE.
    - DACK=1 -> XFER.
  - XFER: DREQ=1.
    - EOP=1 -> DONE. A strobe in the same cycle still completes its pop/push.
    - Else DACK=0 -> IDLE (DMAC released the bus; re-request follows C).
    - Else EN=0 -> IDLE.
    - DREQ stays asserted even when the FIFO stalls; RDY=0 inserts wait states.
  - DONE: DREQ=0. DONE=1 only on the first cycle after entry. Leave to IDLE when EN=0; remain while EN=1.
- Priority: RST > EOP > DACK drop > EN drop.
- DIR changes outside IDLE have no effect.

Decomposition:
- Package dma_pkg:
  - state enum {IDLE, REQ, XFER, DONE}.
  - Constants DIR_IO2MEM=0, DIR_MEM2IO=1.
  - DMA byte width constant = 8.
- Sub-module dma_sync_fifo (DW, DEPTH):
  - Ports: push/pop/data/full/empty/count.
  - Instantiated twice, for RX and TX.

Test Plan:
- IO-to-mem burst:
  - Stimulus: reset; DIR=0, EN=1, THRESH=1; device pushes 5,10,15; DACK=1 from cycle after DREQ; IOR pulsed 3 cycles; EOP with the 3rd IOR.
  - Response: DOUT sequence 5,10,15; one DONE pulse; DREQ=0; RX empty.
- Mem-to-IO:
  - Stimulus: DIR=1; DACK and IOW with DIN=0x8C, 0x03, 0x01; EOP on the last.
  - Response: DEV_RDATA yields 8C, 03, 01 in order with DEV_RREADY=1; DONE once.
- Stall:
  - Stimulus: DIR=0, RX holds 1 byte; IOR held 3 cycles.
  - Response: first pop delivers the byte; RDY=0 afterwards and count stays 0; a new device push raises RDY the next cycle and the following IOR pops it.
- Full and wrap:
  - Stimulus: DEPTH=8; push 9 bytes with no DMA activity.
  - Response: DEV_WREADY=0 after the 8th; the 9th is dropped. Then pop 8 while pushing 4 more: order preserved across the pointer wrap; simultaneous push/pop keeps count.
- Reset mid-transfer:
  - Stimulus: RST=1 during XFER with RX count 3.
  - Response: next cycle DREQ=0, RDY=0, DOUT=0, IDLE, FIFOs empty; pending IOR does nothing.
- DACK drop / threshold:
  - Stimulus: THRESH=4, 3 bytes in RX.
  - Response: DREQ stays 0; the 4th byte raises DREQ. DACK drop without EOP returns to IDLE and re-raises DREQ while C holds; no DONE pulse.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA I/O port and its FIFOs.
package dma_pkg;

    // Byte bus width between the DMAC and the port.
    localparam int DMA_BYTE_W = 8;

    // Transfer direction as latched in dir_q.
    localparam logic DIR_IO2MEM = 1'b0;
    localparam logic DIR_MEM2IO = 1'b1;

    // Request/transfer handshake states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/dma_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Pushes are dropped when full,
// pops are dropped when empty, and the head reads as zero while empty.
module dma_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; the empty flag masks stale entries.
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/dma_io_port.sv
// Peripheral-side DMA port: raises DREQ when its FIFO can sustain a transfer,
// serves DACK/IOR/IOW strobes from the DMAC, and streams bytes to/from a device.
module dma_io_port
    import dma_pkg::*;
#(
    parameter int DW     = DMA_BYTE_W,
    parameter int DEPTH  = 8,
    parameter int THRESH = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          DIR,
    output logic          DREQ,
    input  logic          DACK,
    input  logic          IOR,
    input  logic          IOW,
    input  logic          EOP,
    output logic          RDY,
    output logic [DW-1:0] DOUT,
    input  logic [DW-1:0] DIN,
    input  logic          DEV_WVALID,
    input  logic [DW-1:0] DEV_WDATA,
    output logic          DEV_WREADY,
    output logic          DEV_RVALID,
    output logic [DW-1:0] DEV_RDATA,
    input  logic          DEV_RREADY,
    output logic          DONE
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    state_e        state_q, state_d;
    logic          dir_q, dir_d;
    logic          dreq_q, dreq_d;
    logic          done_q, done_d;
    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic [CW-1:0] rx_count, tx_count;
    logic [DW-1:0] rx_head;
    logic          in_xfer, cond_c, rx_pop, tx_push;

    // Request condition: enough buffered bytes (RX) or free slots (TX).
    assign cond_c = (dir_q == DIR_IO2MEM) ? (rx_count >= THRESH_C)
                                          : ((DEPTH_C - tx_count) >= THRESH_C);

    // The DMAC may only strobe while the selected FIFO can take the access.
    assign in_xfer = (state_q == ST_XFER);
    assign RDY     = in_xfer && ((dir_q == DIR_IO2MEM) ? !rx_empty : !tx_full);
    assign rx_pop  = RDY && DACK && IOR && (dir_q == DIR_IO2MEM);
    assign tx_push = RDY && DACK && IOW && (dir_q == DIR_MEM2IO);

    assign DOUT       = (DACK && (dir_q == DIR_IO2MEM)) ? rx_head : '0;
    assign DEV_WREADY = !rx_full;
    assign DEV_RVALID = !tx_empty;
    assign DREQ       = dreq_q;
    assign DONE       = done_q;

    dma_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (DEV_WVALID),
        .wdata_i (DEV_WDATA),
        .pop_i   (rx_pop),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    dma_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (tx_push),
        .wdata_i (DIN),
        .pop_i   (DEV_RREADY),
        .rdata_o (DEV_RDATA),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    // Next-state logic; in XFER, EOP beats a DACK drop, which beats an EN drop.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                dir_d = DIR;
                if (EN && cond_c) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!EN)       state_d = ST_IDLE;
                else if (DACK) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (EOP)        state_d = ST_DONE;
                else if (!DACK) state_d = ST_IDLE;
                else if (!EN)   state_d = ST_IDLE;
            end
            ST_DONE: begin
                if (!EN) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        dreq_d = (state_d == ST_REQ) || (state_d == ST_XFER);
        done_d = (state_q == ST_XFER) && EOP;
    end

    // State, latched direction and registered DREQ/DONE outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_IO2MEM;
            dreq_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dreq_q  <= dreq_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_dma_io_port.sv
// Bench for dma_io_port: two instances (THRESH=1 and THRESH=4) share one
// stimulus stream; each is compared every cycle against a queue-based model.
module tb_dma_io_port;

    localparam int DEPTH = 8;

    typedef enum {P_IDLE, P_REQ, P_XFER, P_DONE} phase_t;

    logic CLK;
    logic rst, en, dir, dack, ior, iow, eop, dev_wvalid, dev_rready;
    logic [7:0] din, dev_wdata;

    logic [1:0] dreq, rdy, dev_wready, dev_rvalid, done;
    logic [7:0] dout      [2];
    logic [7:0] dev_rdata [2];

    // Reference model state, one set per instance.
    phase_t     m_phase [2];
    logic       m_dir   [2];
    logic       m_done  [2];
    logic [7:0] m_rx    [2][$];
    logic [7:0] m_tx    [2][$];

    int n_checks = 0;
    int n_errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dma_io_port #(.DW(8), .DEPTH(DEPTH), .THRESH(g == 0 ? 1 : 4)) u_dut (
            .CLK        (CLK),
            .RST        (rst),
            .EN         (en),
            .DIR        (dir),
            .DREQ       (dreq[g]),
            .DACK       (dack),
            .IOR        (ior),
            .IOW        (iow),
            .EOP        (eop),
            .RDY        (rdy[g]),
            .DOUT       (dout[g]),
            .DIN        (din),
            .DEV_WVALID (dev_wvalid),
            .DEV_WDATA  (dev_wdata),
            .DEV_WREADY (dev_wready[g]),
            .DEV_RVALID (dev_rvalid[g]),
            .DEV_RDATA  (dev_rdata[g]),
            .DEV_RREADY (dev_rready),
            .DONE       (done[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int thresh_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic model_rdy(input int k);
        if (m_phase[k] != P_XFER) return 1'b0;
        return (m_dir[k] == 1'b0) ? (m_rx[k].size() > 0) : (m_tx[k].size() < DEPTH);
    endfunction

    // Compare every observable output of both instances with the model.
    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic [7:0] exp_dout;
            exp_dout = 8'h00;
            if (dack && !m_dir[k] && m_rx[k].size() > 0) exp_dout = m_rx[k][0];
            check($sformatf("dreq%0d", k), 32'(dreq[k]),
                  32'((m_phase[k] == P_REQ) || (m_phase[k] == P_XFER)));
            check($sformatf("rdy%0d", k), 32'(rdy[k]), 32'(model_rdy(k)));
            check($sformatf("dout%0d", k), 32'(dout[k]), 32'(exp_dout));
            check($sformatf("wready%0d", k), 32'(dev_wready[k]), 32'(m_rx[k].size() < DEPTH));
            check($sformatf("rvalid%0d", k), 32'(dev_rvalid[k]), 32'(m_tx[k].size() > 0));
            check($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
            if (m_tx[k].size() > 0)
                check($sformatf("rdata%0d", k), 32'(dev_rdata[k]), 32'(m_tx[k][0]));
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic   rdy_now, c_ok, pop_rx, push_tx, dev_push, dev_pop;
            phase_t np;
            if (rst) begin
                m_rx[k].delete();
                m_tx[k].delete();
                m_phase[k] = P_IDLE;
                m_dir[k]   = 1'b0;
                m_done[k]  = 1'b0;
                continue;
            end
            rdy_now  = model_rdy(k);
            c_ok     = m_dir[k] ? ((DEPTH - m_tx[k].size()) >= thresh_of(k))
                                : (m_rx[k].size() >= thresh_of(k));
            pop_rx   = (m_phase[k] == P_XFER) && dack && ior && rdy_now && !m_dir[k];
            push_tx  = (m_phase[k] == P_XFER) && dack && iow && rdy_now &&  m_dir[k];
            dev_push = dev_wvalid && (m_rx[k].size() < DEPTH);
            dev_pop  = dev_rready && (m_tx[k].size() > 0);
            np = m_phase[k];
            case (m_phase[k])
                P_IDLE: begin
                    if (en && c_ok) np = P_REQ;
                    m_dir[k] = dir;
                end
                P_REQ:  np = !en ? P_IDLE : (dack ? P_XFER : P_REQ);
                P_XFER: np = eop ? P_DONE : ((!dack || !en) ? P_IDLE : P_XFER);
                P_DONE: np = en ? P_DONE : P_IDLE;
                default: np = P_IDLE;
            endcase
            m_done[k]  = (m_phase[k] == P_XFER) && eop;
            m_phase[k] = np;
            if (pop_rx)   void'(m_rx[k].pop_front());
            if (dev_push) m_rx[k].push_back(dev_wdata);
            if (dev_pop)  void'(m_tx[k].pop_front());
            if (push_tx)  m_tx[k].push_back(din);
        end
    endtask

    // One cycle: inputs are set after a falling edge, checked, then clocked.
    task automatic tick();
        #1;
        check_outputs();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        rst = 1'b0; en = 1'b0; dir = 1'b0; dack = 1'b0; ior = 1'b0; iow = 1'b0;
        eop = 1'b0; dev_wvalid = 1'b0; dev_rready = 1'b0; din = 8'h00; dev_wdata = 8'h00;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        model_step();
        tick();
        rst = 1'b0; dack = 1'b1;
        tick();
        dack = 1'b0;

        // IO-to-mem burst: 5,10,15 then three IOR with EOP on the last.
        dir = 1'b0; tick();
        en = 1'b1; dev_wvalid = 1'b1;
        dev_wdata = 8'd5;  tick();
        dev_wdata = 8'd10; tick();
        dev_wdata = 8'd15; tick();
        dev_wvalid = 1'b0; dack = 1'b1; tick();
        ior = 1'b1; tick(); tick();
        eop = 1'b1; tick();
        ior = 1'b0; eop = 1'b0; dack = 1'b0; tick(); tick();
        en = 1'b0; tick();

        // Threshold and DACK drop without EOP.
        en = 1'b1; dev_wvalid = 1'b1; dev_wdata = 8'd20; tick();
        dev_wvalid = 1'b0; tick(); tick();
        dack = 1'b1; tick(); tick();
        dack = 1'b0; repeat (4) tick();

        // Reset in the middle of a transfer with an IOR pending.
        dack = 1'b1; tick(); tick();
        ior = 1'b1; rst = 1'b1; tick();
        rst = 1'b0; tick(); tick();
        ior = 1'b0; dack = 1'b0; en = 1'b0; tick();

        // Stall: one byte, IOR held, a late device push refills RX.
        dev_wvalid = 1'b1; dev_wdata = 8'h3C; tick();
        dev_wvalid = 1'b0; en = 1'b1; tick(); tick();
        dack = 1'b1; tick();
        ior = 1'b1; tick(); tick();
        dev_wvalid = 1'b1; dev_wdata = 8'h77; tick();
        dev_wvalid = 1'b0; tick(); tick();
        ior = 1'b0; eop = 1'b1; tick();
        eop = 1'b0; dack = 1'b0; en = 1'b0; tick(); tick();

        // Mem-to-IO: 8C, 03, 01 written by the DMAC, then drained by the device.
        dir = 1'b1; tick();
        en = 1'b1; tick(); tick();
        dack = 1'b1; tick();
        iow = 1'b1; din = 8'h8C; tick();
        din = 8'h03; tick();
        din = 8'h01; eop = 1'b1; tick();
        iow = 1'b0; eop = 1'b0; dack = 1'b0; dev_rready = 1'b1; repeat (4) tick();
        dev_rready = 1'b0; en = 1'b0; dir = 1'b0; tick();

        // Full and wrap: nine pushes, then eight pops overlapping four pushes.
        dev_wvalid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            dev_wdata = 8'(8'hA0 + i);
            tick();
        end
        dev_wvalid = 1'b0; en = 1'b1; tick(); tick();
        dack = 1'b1; tick();
        ior = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dev_wvalid = (i < 4);
            dev_wdata  = 8'(8'hB0 + i);
            tick();
        end
        ior = 1'b0; dack = 1'b0; en = 1'b0; dev_wvalid = 1'b0; tick(); tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            en         = ($urandom_range(0, 9) != 0);
            dir        = 1'($urandom_range(0, 1));
            dack       = ($urandom_range(0, 9) < 7);
            ior        = 1'($urandom_range(0, 1));
            iow        = 1'($urandom_range(0, 1));
            eop        = ($urandom_range(0, 9) == 0);
            dev_wvalid = 1'($urandom_range(0, 1));
            dev_rready = 1'($urandom_range(0, 1));
            din        = 8'($urandom);
            dev_wdata  = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
